// File: rtl/sram_2p_bwe.sv
// sram_2p_bwe: 1rw+1r SRAM with byte write masks, 1/2-cycle read latency, write forwarding, collision counter
module sram_2p_bwe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int READ_LAT   = 1,
  parameter int FORWARD    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    csb0,
  input  logic                    web0,
  input  logic [DATA_WIDTH/8-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH-1:0]   din0,
  output logic [DATA_WIDTH-1:0]   dout0,
  output logic                    rvalid0,
  input  logic                    csb1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  output logic [DATA_WIDTH-1:0]   dout1,
  output logic                    rvalid1,
  output logic [CNT_WIDTH-1:0]    collision_cnt
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] old0, old1, merged, rd1_d;
  logic [DATA_WIDTH-1:0] s0_d_q, s1_d_q;
  logic                  s0_v_q, s1_v_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  wr, rd0, rd1, col;
  assign wr   = !csb0 && !web0;
  assign rd0  = !csb0 && web0;
  assign rd1  = !csb1;
  assign col  = wr && rd1 && (addr0 == addr1);
  assign old0 = mem_q[addr0];
  assign old1 = mem_q[addr1];
  always_comb begin
    merged = old1;
    for (int b = 0; b < NB; b++)
      if (wmask0[b]) merged[8*b +: 8] = din0[8*b +: 8];
    rd1_d = (FORWARD != 0 && col) ? merged : old1;
    cnt_d = (col && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  // Array is never reset; writes are suppressed while rst is held
  always_ff @(posedge clk)
    if (!rst && wr)
      for (int b = 0; b < NB; b++)
        if (wmask0[b]) mem_q[addr0][8*b +: 8] <= din0[8*b +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s0_d_q <= '0;
      s0_v_q <= 1'b0;
      s1_d_q <= '0;
      s1_v_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s0_v_q <= rd0;
      s1_v_q <= rd1;
      if (rd0) s0_d_q <= old0;
      if (rd1) s1_d_q <= rd1_d;
      cnt_q  <= cnt_d;
    end
  assign collision_cnt = cnt_q;
  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] o0_d_q, o1_d_q;
      logic                  o0_v_q, o1_v_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          o0_d_q <= '0;
          o0_v_q <= 1'b0;
          o1_d_q <= '0;
          o1_v_q <= 1'b0;
        end else begin
          o0_v_q <= s0_v_q;
          o1_v_q <= s1_v_q;
          if (s0_v_q) o0_d_q <= s0_d_q;
          if (s1_v_q) o1_d_q <= s1_d_q;
        end
      assign dout0   = o0_d_q;
      assign rvalid0 = o0_v_q;
      assign dout1   = o1_d_q;
      assign rvalid1 = o1_v_q;
    end else begin : g_lat1
      assign dout0   = s0_d_q;
      assign rvalid0 = s0_v_q;
      assign dout1   = s1_d_q;
      assign rvalid1 = s1_v_q;
    end
  endgenerate
endmodule

// File: tb/tb_sram_2p_bwe.sv
// tb_sram_2p_bwe: two instances (LAT1/FWD1/CNT16 and LAT2/FWD0/CNT4) on one stimulus bus vs a word-level model
module tb_sram_2p_bwe;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [3:0]  wmask0 = '0;
  logic [10:0] addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0;
  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic        rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  sram_2p_bwe #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .READ_LAT(1), .FORWARD(1), .CNT_WIDTH(16)) u0 (
    .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0_a), .rvalid0(rvalid0_a), .csb1(csb1), .addr1(addr1), .dout1(dout1_a),
    .rvalid1(rvalid1_a), .collision_cnt(cnt_a));
  sram_2p_bwe #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .READ_LAT(2), .FORWARD(0), .CNT_WIDTH(4)) u1 (
    .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0_b), .rvalid0(rvalid0_b), .csb1(csb1), .addr1(addr1), .dout1(dout1_b),
    .rvalid1(rvalid1_b), .collision_cnt(cnt_b));

  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // reference model: word array plus "known" flags, per-instance expected outputs
  logic [31:0] mem [2048];
  bit          known [2048];
  int          lat [2] = '{1, 2};
  bit          fwdp [2] = '{1'b1, 1'b0};
  int          cmax [2] = '{65535, 15};
  logic [31:0] ed0 [2], ed1 [2], pd0 [2], pd1 [2];
  bit          ev0 [2], ev1 [2], ek0 [2], ek1 [2], pv0 [2], pv1 [2], pk0 [2], pk1 [2];
  int          ecnt [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ed0[k] = '0; ed1[k] = '0; ev0[k] = 0; ev1[k] = 0; ek0[k] = 1; ek1[k] = 1;
      pv0[k] = 0; pv1[k] = 0; ecnt[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic [31:0] mw, nd1;
    bit wr, r0, r1, col, nk1;
    if (rst) return;
    wr = !csb0 && !web0;
    r0 = !csb0 && web0;
    r1 = !csb1;
    mw = mem[addr0];
    for (int b = 0; b < 4; b++) if (wmask0[b]) mw[8*b +: 8] = din0[8*b +: 8];
    col = wr && r1 && addr0 == addr1;
    for (int k = 0; k < 2; k++) begin
      if (col && ecnt[k] < cmax[k]) ecnt[k]++;
      nd1 = (col && fwdp[k]) ? mw : mem[addr1];
      nk1 = (col && fwdp[k]) ? (known[addr0] || wmask0 == 4'hF) : known[addr1];
      if (lat[k] == 2) begin
        ev0[k] = pv0[k]; if (pv0[k]) begin ed0[k] = pd0[k]; ek0[k] = pk0[k]; end
        ev1[k] = pv1[k]; if (pv1[k]) begin ed1[k] = pd1[k]; ek1[k] = pk1[k]; end
        pv0[k] = r0; pd0[k] = mem[addr0]; pk0[k] = known[addr0];
        pv1[k] = r1; pd1[k] = nd1; pk1[k] = nk1;
      end else begin
        ev0[k] = r0; if (r0) begin ed0[k] = mem[addr0]; ek0[k] = known[addr0]; end
        ev1[k] = r1; if (r1) begin ed1[k] = nd1; ek1[k] = nk1; end
      end
    end
    if (wr) begin
      mem[addr0] = mw;
      known[addr0] = known[addr0] || wmask0 == 4'hF;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      if (ek0[k]) chk($sformatf("u%0d.dout0", k), k == 0 ? dout0_a : dout0_b, ed0[k]);
      chk($sformatf("u%0d.rvalid0", k), k == 0 ? rvalid0_a : rvalid0_b, 64'(ev0[k]));
      if (ek1[k]) chk($sformatf("u%0d.dout1", k), k == 0 ? dout1_a : dout1_b, ed1[k]);
      chk($sformatf("u%0d.rvalid1", k), k == 0 ? rvalid1_a : rvalid1_b, 64'(ev1[k]));
      chk($sformatf("u%0d.cnt", k), k == 0 ? 64'(cnt_a) : 64'(cnt_b), 64'(ecnt[k]));
    end
  endtask

  task automatic step(input logic c0, input logic w0, input logic [3:0] m, input logic [10:0] a0,
                      input logic [31:0] d, input logic c1, input logic [10:0] a1);
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 4'h0, 11'h0, 32'h0, 1'b1, 11'h0);
  endtask

  typedef struct {
    logic c0, w0; logic [3:0] m; logic [10:0] a0; logic [31:0] d; logic c1; logic [10:0] a1;
    logic [31:0] e_d0; logic e_v0; logic [31:0] e_d1; logic e_v1; int e_cnt;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 4'hF, 11'h010, 32'hFFFFFFFF, 1'b1, 11'h000, 32'h0, 1'b0, 32'h0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b0, 4'h5, 11'h010, 32'h00000000, 1'b1, 11'h000, 32'h0, 1'b0, 32'h0, 1'b0, 0};
    tbl[2] = '{1'b0, 1'b1, 4'h0, 11'h010, 32'h0, 1'b1, 11'h000, 32'hFF00FF00, 1'b1, 32'h0, 1'b0, 0};
    tbl[3] = '{1'b0, 1'b0, 4'hF, 11'h003, 32'h11223344, 1'b0, 11'h010, 32'hFF00FF00, 1'b0, 32'hFF00FF00, 1'b1, 0};
    tbl[4] = '{1'b0, 1'b0, 4'h3, 11'h003, 32'hAABBCCDD, 1'b0, 11'h003, 32'hFF00FF00, 1'b0, 32'h1122CCDD, 1'b1, 1};
    tbl[5] = '{1'b0, 1'b1, 4'h0, 11'h003, 32'h0, 1'b0, 11'h003, 32'h1122CCDD, 1'b1, 32'h1122CCDD, 1'b1, 1};
    tbl[6] = '{1'b0, 1'b0, 4'h0, 11'h003, 32'hFFFFFFFF, 1'b0, 11'h003, 32'h1122CCDD, 1'b0, 32'h1122CCDD, 1'b1, 2};
    tbl[7] = '{1'b1, 1'b1, 4'h0, 11'h000, 32'h0, 1'b1, 11'h000, 32'h1122CCDD, 1'b0, 32'h1122CCDD, 1'b0, 2};
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].c0, tbl[i].w0, tbl[i].m, tbl[i].a0, tbl[i].d, tbl[i].c1, tbl[i].a1);
      chk($sformatf("vec%0d.dout0", i), dout0_a, tbl[i].e_d0);
      chk($sformatf("vec%0d.rvalid0", i), rvalid0_a, tbl[i].e_v0);
      chk($sformatf("vec%0d.dout1", i), dout1_a, tbl[i].e_d1);
      chk($sformatf("vec%0d.rvalid1", i), rvalid1_a, tbl[i].e_v1);
      chk($sformatf("vec%0d.cnt", i), cnt_a, 64'(tbl[i].e_cnt));
      if (i == 5) begin
        chk("nofwd.dout1", dout1_b, 32'h11223344);
        chk("nofwd.cnt", cnt_b, 64'd1);
      end
    end
    // dual-port stream
    for (int i = 0; i < 2048; i++) step(1'b0, 1'b0, 4'hF, 11'(i), 32'(i * 3), 1'b1, 11'h0);
    for (int i = 0; i < 2048; i++) step(1'b0, 1'b1, 4'h0, 11'(i), 32'h0, 1'b0, 11'(2047 - i));
    idle();
    // idle hold
    step(1'b0, 1'b0, 4'hF, 11'h020, 32'hDEADBEEF, 1'b1, 11'h0);
    step(1'b0, 1'b1, 4'h0, 11'h020, 32'h0, 1'b0, 11'h020);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("hold.dout0", dout0_a, 32'hDEADBEEF);
      chk("hold.rvalid0", rvalid0_a, 64'd0);
      chk("hold.dout1", dout1_a, 32'hDEADBEEF);
      chk("hold.rvalid1", rvalid1_a, 64'd0);
    end
    chk("hold.lat2.dout0", dout0_b, 32'hDEADBEEF);
    // reset mid-read on the latency-2 instance; the write held during reset must not commit
    step(1'b0, 1'b1, 4'h0, 11'h020, 32'h0, 1'b0, 11'h021);
    rst = 1'b1;
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; din0 = 32'h12345678; addr0 = 11'h020;
    model_reset();
    #1 check_all();
    chk("rst.rvalid0", rvalid0_b, 64'd0);
    chk("rst.dout0", dout0_b, 64'd0);
    chk("rst.cnt", cnt_b, 64'd0);
    @(posedge clk);
    model_edge();
    #1 check_all();
    chk("rst.edge.rvalid0", rvalid0_b, 64'd0);
    rst = 1'b0;
    step(1'b0, 1'b1, 4'h0, 11'h020, 32'h0, 1'b0, 11'h021);
    idle();
    chk("rst.after.dout0", dout0_b, 32'hDEADBEEF);
    chk("rst.after.dout1", dout1_b, 32'h63);
    // counter saturation
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'($urandom), 11'h005, $urandom, 1'b0, 11'h005);
    chk("sat.cnt", cnt_b, 64'd15);
    idle();
    chk("sat.hold", cnt_b, 64'd15);
    // randomized traffic concentrated on a few addresses to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      logic [10:0] a0, a1;
      a0 = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 1) == 0) ? a0 : 11'($urandom_range(0, 7));
      step(1'($urandom_range(0, 4) == 0), 1'($urandom), 4'($urandom), a0, $urandom,
           1'($urandom_range(0, 4) == 0), a1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sram_2p_bwe.md
# sram_2p_bwe

Parametrised single-clock dual-port SRAM (port 0 read/write, port 1 read-only) with byte write masks, configurable read latency, same-address read/write forwarding and a collision counter. It is the synthesizable next-generation replacement for the fixed 32x2048 1rw1r macro model. It sits between the core's instruction/data fetch paths and on-chip memory in riscv_top. Unlike the old model, outputs hold instead of going X, and read data carries a valid strobe.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 11, address bits; depth = 1 << ADDR_WIDTH
- READ_LAT, 1, read latency in clock edges; legal values 1 or 2 (2 adds an output register)
- FORWARD, 1, 1 = port 1 returns newly written bytes on a same-address collision; 0 = returns old data
- CNT_WIDTH, 16, collision counter width

- clk  in  1  single clock; all activity on the rising edge
- rst  in  1  asynchronous, active-high reset
- csb0  in  1  port 0 chip select, active low
- web0  in  1  port 0 write enable, active low (0 = write, 1 = read)
- wmask0  in  DATA_WIDTH/8  byte write mask; bit i enables din0[8i+7:8i]
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH  port 0 write data
- dout0  out  DATA_WIDTH  port 0 read data
- rvalid0  out  1  dout0 carries fresh read data this cycle
- csb1  in  1  port 1 chip select, active low
- addr1  in  ADDR_WIDTH  port 1 address
- dout1  out  DATA_WIDTH  port 1 read data
- rvalid1  out  1  dout1 carries fresh read data this cycle
- collision_cnt  out  CNT_WIDTH  saturating count of same-address write/read collisions

## Operation
- Reset values: dout0 = 0, dout1 = 0, rvalid0 = 0, rvalid1 = 0, collision_cnt = 0. All pipeline registers are cleared.
- Memory array is not reset. Its contents are retained across reset.
- Port 0 write:
  - Condition: csb0 = 0 and web0 = 0 at edge E.
  - Bytes with wmask0[i] = 1 are written at E. Other bytes are unchanged.
  - A write with wmask0 = 0 is a no-op but still counts as a write for collision detection.
- Port 0 read: csb0 = 0 and web0 = 1 at E reads mem[addr0] as it was before E.
- Port 0 writes produce no read data. dout0 holds and rvalid0 = 0 for that slot.
- Port 1 read: csb1 = 0 at E reads mem[addr1].
- Collision:
  - Condition: port 0 write and port 1 read at the same edge with addr0 == addr1.
  - FORWARD=1: dout1 = merged word (din0 bytes where wmask0 = 1, old bytes elsewhere).
  - FORWARD=0: dout1 = old word.
  - In both modes collision_cnt increments by 1 and saturates at all-ones.
- Idle port (csb = 1): its dout holds its last value and its rvalid = 0.
- Reads sampled at an edge observe every write committed at earlier edges.

## Timing
- Request sampled at rising edge E.
- READ_LAT=1: dout/rvalid update at E and are valid during the following cycle.
- READ_LAT=2: dout/rvalid update at E+1.
- Fully pipelined: one request per port per cycle, with no stalls and no backpressure.
- rvalid is a one-cycle strobe per read. Back-to-back reads hold it high continuously.
- Write commit: a read at E+1 to the same address returns the written data with no forwarding needed.
- Reset asserted mid-operation:
  - In-flight reads are dropped, rvalid drops to 0 asynchronously and dout clears to 0.
  - No write is committed at an edge while rst = 1.
- Reset deassertion: the first request is accepted at the first rising edge with rst = 0.
- The collision counter updates at edge E, the same edge as the collision.

## Test plan
- Byte mask write:
  - Write 0xFFFFFFFF to addr 0x010 (wmask0 = 0xF), then 0x00000000 with wmask0 = 0x5, then read port 0.
  - Required: dout0 = 0xFF00FF00 and rvalid0 = 1 at E (READ_LAT=1) or at E+1 (READ_LAT=2).
- Collision, FORWARD=1:
  - addr 0x3 holds 0x11223344. At one edge, port 0 writes 0xAABBCCDD with wmask0 = 0x3 and port 1 reads 0x3.
  - Required: dout1 = 0x1122CCDD and collision_cnt goes 0 -> 1.
  - Repeat with FORWARD=0: required dout1 = 0x11223344.
- Dual-port stream:
  - Fill 0..2047 with addr*3, then read port 0 ascending and port 1 descending for 2048 consecutive cycles.
  - Required: every value correct and rvalid0 = rvalid1 = 1 continuously after the latency.
- Reset mid-read (READ_LAT=2):
  - Assert rst one cycle after a read request.
  - Required: rvalid0 stays 0, dout0 = 0 and collision_cnt = 0.
  - After release, a read of a location written before reset returns the stored value.
- Counter saturation:
  - CNT_WIDTH=4, 20 consecutive collisions.
  - Required: collision_cnt = 15 and holds there.
- Idle hold:
  - Read 0xDEADBEEF, then deassert the chip select for 5 cycles.
  - Required: dout holds 0xDEADBEEF and rvalid = 0 for all 5 cycles.
